// File: rtl/burst_ram_pkg.sv
// burst_ram_pkg: state encoding and timing defaults shared by the burst RAM emulator and the cache.
package burst_ram_pkg;

    typedef enum logic [2:0] {INIT, IDLE, READ_DELAY, READ_BURST, WRITE_BURST} br_state_e;

    localparam int BR_CYCLES_BEFORE_INITIATED  = 10;
    localparam int BR_CYCLES_BEFORE_DATA_VALID = 6;
    localparam int BR_BURST_COUNT              = 4;
    localparam int BR_COMMAND_INTERVAL         = 14;
    localparam int COMMAND_DELAY_INTERVAL      = BR_COMMAND_INTERVAL;

endpackage

// File: rtl/burst_ram_mem.sv
// burst_ram_mem: single-port byte-enabled 64-bit RAM with registered read.
module burst_ram_mem #(
    parameter int    AW        = 21,
    parameter string DATA_FILE = ""
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [7:0]    be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [63:0]   wdata_i,
    output logic [63:0]   rdata_o
);

    logic [63:0] mem_q [2**AW];
    logic [63:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en_i && we_i)
            for (int i = 0; i < 8; i++)
                if (be_i[i]) mem_q[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rdata_q <= '0;
        else if (en_i && !we_i)
            rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/burst_ram_emulator.sv
// burst_ram_emulator: block-RAM stand-in for the PSRAM burst controller on the br_* bus.
// Define BURST_RAM_DATA_MASK_EN to honour data_mask per byte on writes.
module burst_ram_emulator
    import burst_ram_pkg::*;
#(
    parameter int    DEPTH_BITWIDTH           = 21,
    parameter string DATA_FILE                = "",
    parameter int    CYCLES_BEFORE_INITIATED  = BR_CYCLES_BEFORE_INITIATED,
    parameter int    CYCLES_BEFORE_DATA_VALID = BR_CYCLES_BEFORE_DATA_VALID,
    parameter int    BURST_COUNT              = BR_BURST_COUNT,
    parameter int    COMMAND_INTERVAL         = BR_COMMAND_INTERVAL
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cmd,
    input  logic                      cmd_en,
    input  logic [DEPTH_BITWIDTH-1:0] addr,
    input  logic [63:0]               wr_data,
    input  logic [7:0]                data_mask,
    output logic [63:0]               rd_data,
    output logic                      rd_data_valid,
    output logic                      init_calib,
    output logic                      cmd_dropped
);

    localparam int CW = 16;
    localparam int IW = $clog2(COMMAND_INTERVAL + 1);

    generate
        if (COMMAND_INTERVAL < CYCLES_BEFORE_DATA_VALID + BURST_COUNT || CYCLES_BEFORE_DATA_VALID < 2 ||
            BURST_COUNT < 2 || CYCLES_BEFORE_INITIATED < 1) begin : g_bad_params
            $error("burst_ram_emulator: invalid timing parameters");
        end
    endgenerate

    br_state_e                 state_q;
    logic [CW-1:0]             cnt_q;
    logic [IW-1:0]             ivl_q;
    logic [DEPTH_BITWIDTH-1:0] ptr_q;
    logic                      valid_q, calib_q, dropped_q;
    logic                      accept, mem_en, mem_we;
    logic [DEPTH_BITWIDTH-1:0] mem_addr;
    logic [7:0]                mem_be;

`ifdef BURST_RAM_DATA_MASK_EN
    assign mem_be = ~data_mask;
`else
    logic unused_mask;
    assign unused_mask = ^data_mask;
    assign mem_be      = 8'hFF;
`endif

    always_comb begin
        accept   = cmd_en && state_q == IDLE && ivl_q == '0;
        mem_we   = state_q == WRITE_BURST || (accept && cmd);
        mem_en   = mem_we || state_q == READ_BURST;
        mem_addr = state_q == IDLE ? addr : ptr_q;
    end

    // READ_BURST cycles issue RAM reads; valid follows one edge later with the registered data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= INIT;
            cnt_q     <= '0;
            ivl_q     <= '0;
            ptr_q     <= '0;
            valid_q   <= 1'b0;
            calib_q   <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            valid_q <= state_q == READ_BURST;
            if (cmd_en && !accept) dropped_q <= 1'b1;
            ivl_q <= accept ? IW'(COMMAND_INTERVAL - 1) : (ivl_q != '0 ? ivl_q - 1'b1 : ivl_q);
            case (state_q)
                INIT: begin
                    if (cnt_q == CW'(CYCLES_BEFORE_INITIATED - 1)) begin
                        calib_q <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                IDLE: begin
                    if (accept) begin
                        ptr_q   <= cmd ? addr + 1'b1 : addr;
                        cnt_q   <= cmd ? CW'(BURST_COUNT - 2) : CW'(CYCLES_BEFORE_DATA_VALID - 2);
                        state_q <= cmd ? WRITE_BURST : READ_DELAY;
                    end
                end
                READ_DELAY: begin
                    cnt_q   <= cnt_q == '0 ? CW'(BURST_COUNT - 1) : cnt_q - 1'b1;
                    state_q <= cnt_q == '0 ? READ_BURST : READ_DELAY;
                end
                READ_BURST, WRITE_BURST: begin
                    ptr_q   <= ptr_q + 1'b1;
                    cnt_q   <= cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
                    state_q <= cnt_q == '0 ? IDLE : state_q;
                end
                default: state_q <= INIT;
            endcase
        end
    end

    burst_ram_mem #(
        .AW        (DEPTH_BITWIDTH),
        .DATA_FILE (DATA_FILE)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (mem_en),
        .we_i    (mem_we),
        .be_i    (mem_be),
        .addr_i  (mem_addr),
        .wdata_i (wr_data),
        .rdata_o (rd_data)
    );

    assign rd_data_valid = valid_q;
    assign init_calib    = calib_q;
    assign cmd_dropped   = dropped_q;

endmodule

// File: tb/tb_burst_ram_emulator.sv
// tb_burst_ram_emulator: table-driven burst traffic with a read-data scoreboard plus timing/reset corner cases.
module tb_burst_ram_emulator;

    localparam int AW  = 5;
    localparam int GAP = 14;

    logic          clk = 1'b0, rst_n = 1'b0, cmd = 1'b0, cmd_en = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [63:0]   wr_data = '0;
    logic [7:0]    data_mask = '0;
    logic [63:0]   rd_data;
    logic          rd_data_valid, init_calib, cmd_dropped;

    int          checks = 0, errors = 0, valid_cnt = 0;
    logic [63:0] exp_q[$];

    typedef struct packed {
        logic             wr;
        logic [AW-1:0]    a;
        logic [3:0][63:0] d;
        logic [7:0]       m;
    } op_t;

    op_t ops[9];

    burst_ram_emulator #(.DEPTH_BITWIDTH(AW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd           (cmd),
        .cmd_en        (cmd_en),
        .addr          (addr),
        .wr_data       (wr_data),
        .data_mask     (data_mask),
        .rd_data       (rd_data),
        .rd_data_valid (rd_data_valid),
        .init_calib    (init_calib),
        .cmd_dropped   (cmd_dropped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && rd_data_valid) begin
            valid_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got valid word %h expected no valid word", rd_data);
            end else begin
                chk("rd_data", rd_data, exp_q.pop_front());
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [3:0][63:0] d, input logic [7:0] m);
        cmd_en    = 1'b1;
        cmd       = wr;
        addr      = a;
        data_mask = m;
        wr_data   = wr ? d[0] : '0;
        if (!wr)
            for (int k = 0; k < 4; k++) exp_q.push_back(d[k]);
        cycle();
        cmd_en = 1'b0;
        for (int k = 1; k < 4; k++) begin
            if (wr) wr_data = d[k];
            cycle();
        end
        repeat (GAP - 4) cycle();
    endtask

    task automatic wait_calib();
        int n = 0;
        while (!init_calib && n < 50) begin
            cycle();
            n++;
        end
        chk("calib_timeout", {63'd0, init_calib}, 64'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
        wait_calib();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        ops[0] = '{1'b1, 5'h10, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 8'h00};
        ops[1] = '{1'b0, 5'h10, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 8'h00};
        ops[2] = '{1'b1, 5'h00, {64'hB3B3_B3B3_B3B3_B3B3, 64'hB2B2_B2B2_B2B2_B2B2, 64'hB1B1_B1B1_B1B1_B1B1, 64'hB0B0_B0B0_B0B0_B0B0}, 8'h00};
        ops[3] = '{1'b1, 5'h1E, {64'hA3A3_A3A3_A3A3_A3A3, 64'hA2A2_A2A2_A2A2_A2A2, 64'hA1A1_A1A1_A1A1_A1A1, 64'hA0A0_A0A0_A0A0_A0A0}, 8'h00};
        ops[4] = '{1'b0, 5'h00, {64'hB3B3_B3B3_B3B3_B3B3, 64'hB2B2_B2B2_B2B2_B2B2, 64'hA3A3_A3A3_A3A3_A3A3, 64'hA2A2_A2A2_A2A2_A2A2}, 8'h00};
        ops[5] = '{1'b0, 5'h1E, {64'hA3A3_A3A3_A3A3_A3A3, 64'hA2A2_A2A2_A2A2_A2A2, 64'hA1A1_A1A1_A1A1_A1A1, 64'hA0A0_A0A0_A0A0_A0A0}, 8'h00};
        ops[6] = '{1'b1, 5'h08, {4{64'hFFFF_FFFF_FFFF_FFFF}}, 8'h00};
        ops[7] = '{1'b1, 5'h08, {64'hC0DE_0003_5A5A_0003, 64'hC0DE_0002_5A5A_0002, 64'hC0DE_0001_5A5A_0001, 64'hC0DE_0000_5A5A_0000}, 8'h0F};
`ifdef BURST_RAM_DATA_MASK_EN
        ops[8] = '{1'b0, 5'h08, {64'hC0DE_0003_FFFF_FFFF, 64'hC0DE_0002_FFFF_FFFF, 64'hC0DE_0001_FFFF_FFFF, 64'hC0DE_0000_FFFF_FFFF}, 8'h00};
`else
        ops[8] = '{1'b0, 5'h08, {64'hC0DE_0003_5A5A_0003, 64'hC0DE_0002_5A5A_0002, 64'hC0DE_0001_5A5A_0001, 64'hC0DE_0000_5A5A_0000}, 8'h00};
`endif

        repeat (3) cycle();
        chk("reset_rd_data", rd_data, 64'd0);
        chk("reset_valid", {63'd0, rd_data_valid}, 64'd0);
        chk("reset_calib", {63'd0, init_calib}, 64'd0);
        chk("reset_dropped", {63'd0, cmd_dropped}, 64'd0);
        rst_n = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            if (i == 5) cmd_en = 1'b1;
            cycle();
            cmd_en = 1'b0;
            chk("init_calib", {63'd0, init_calib}, {63'd0, i == 10});
            chk("early_drop", {63'd0, cmd_dropped}, {63'd0, i >= 5});
        end

        do_reset();
        for (int i = 0; i < 9; i++) issue(ops[i].wr, ops[i].a, ops[i].d, ops[i].m);
        chk("table_no_drop", {63'd0, cmd_dropped}, 64'd0);

        cmd_en = 1'b1;
        cmd    = 1'b0;
        addr   = 5'h10;
        exp_q.push_back(64'h1111_1111_1111_1111);
        exp_q.push_back(64'h2222_2222_2222_2222);
        exp_q.push_back(64'h3333_3333_3333_3333);
        exp_q.push_back(64'h4444_4444_4444_4444);
        for (int k = 0; k < GAP; k++) begin
            cycle();
            cmd_en = 1'b0;
            chk("valid_timing", {63'd0, rd_data_valid}, {63'd0, k >= 6 && k <= 9});
        end

        valid_cnt = 0;
        cmd_en = 1'b1;
        addr   = 5'h10;
        exp_q.push_back(64'h1111_1111_1111_1111);
        exp_q.push_back(64'h2222_2222_2222_2222);
        exp_q.push_back(64'h3333_3333_3333_3333);
        exp_q.push_back(64'h4444_4444_4444_4444);
        for (int k = 0; k < GAP; k++) begin
            cycle();
            cmd_en = k == 4;
            addr   = k == 4 ? 5'h00 : 5'h10;
            if (k == 5) chk("dropped_set", {63'd0, cmd_dropped}, 64'd1);
        end
        chk("drop_valid_count", valid_cnt, 64'd4);

        do_reset();
        chk("reinit_dropped_clear", {63'd0, cmd_dropped}, 64'd0);
        cmd_en = 1'b1;
        addr   = 5'h10;
        exp_q.push_back(64'h1111_1111_1111_1111);
        exp_q.push_back(64'h2222_2222_2222_2222);
        for (int k = 0; k < 8; k++) begin
            cycle();
            cmd_en = 1'b0;
        end
        chk("valid_before_reset", {63'd0, rd_data_valid}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_valid", {63'd0, rd_data_valid}, 64'd0);
        chk("abort_rd_data", rd_data, 64'd0);
        exp_q.delete();
        cycle();
        rst_n = 1'b1;
        wait_calib();
        issue(1'b0, 5'h10, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 8'h00);
        chk("scoreboard_drained", exp_q.size(), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
